// File: rtl/mainfsm.sv
// Moore main controller FSM of the multi-cycle processor: sequences fetch, decode,
// execute, memory and writeback cycles and drives the raw datapath selects/strobes.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
  } ctrl_t;

  // Plain logic (not the enum type) so codes 11-15 are representable and recoverable.
  logic [3:0] r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;

  function automatic ctrl_t decode_ctrl(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.nextpc    = 1'b1;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_MEMADR:   c.alusrcb = 2'b01;
      S_MEMREAD:  c.adrsrc  = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regw      = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      S_EXECUTER: c.aluop = 1'b1;
      S_EXECUTEI: begin
        c.alusrcb = 2'b01;
        c.aluop   = 1'b1;
      end
      S_ALUWB:    c.regw = 1'b1;
      S_BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.branch    = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; Op/Funct are only looked at in DECODE and MEMADR.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // State register; outputs are registered from the decoded next state so they
  // always match State without any decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= decode_ctrl(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next);
    end
  end

  assign IRWrite   = r_ctrl.irwrite;
  assign AdrSrc    = r_ctrl.adrsrc;
  assign ALUSrcA   = r_ctrl.alusrca;
  assign ALUSrcB   = r_ctrl.alusrcb;
  assign ResultSrc = r_ctrl.resultsrc;
  assign ALUOp     = r_ctrl.aluop;
  assign NextPC    = r_ctrl.nextpc;
  assign RegW      = r_ctrl.regw;
  assign MemW      = r_ctrl.memw;
  assign Branch    = r_ctrl.branch;
  assign State     = r_state;

endmodule
